accu_seq: RTL and testbench

- Operand sequencer that sits directly upstream of the 4-bit adder-accumulator and drives its a/b/sel inputs.
- Accepts a stream of 4-bit operands over a valid/ready handshake and sums a programmed count of them.
- Tracks sticky overflow from the accumulator carry.
- Presents the final total on a held result interface with its own valid/ready handshake.

---
 rtl/accu_seq.sv | 91 +++++++++
 tb/tb_accu_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/accu_seq.sv
// accu_seq: operand sequencer feeding a 4-bit adder-accumulator, with handshaked result.
// Optional ACCU_SEQ_SAT_EN: saturate res_sum to 4'hF when the sequence overflowed.
module accu_seq #(
  parameter int CNT_W = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       acc_a,
  output logic [3:0]       acc_b,
  output logic             acc_sel,
  input  logic [3:0]       acc_sum,
  input  logic             acc_carry,
  output logic [3:0]       res_sum,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, WAIT, RESULT} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       res_sum_q, res_sum_d;
  logic             res_ovf_q, res_ovf_d;
  logic             adding, xfer;
  logic [3:0]       fin_sum;
  // Outside LOAD/ACCUM the accumulator sees b=0, sel=1, so its register holds.
  assign adding    = state_q == LOAD || state_q == ACCUM;
  assign xfer      = in_valid & adding;
  assign in_ready  = adding;
  assign acc_a     = 4'h0;
  assign acc_sel   = state_q != LOAD;
  assign acc_b     = xfer ? in_data : 4'h0;
  assign res_sum   = res_sum_q;
  assign res_ovf   = res_ovf_q;
  assign res_valid = state_q == RESULT;
  assign busy      = state_q != IDLE;
`ifdef ACCU_SEQ_SAT_EN
  assign fin_sum = ovf_q ? 4'hF : acc_sum;
`else
  assign fin_sum = acc_sum;
`endif
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    res_sum_d = res_sum_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d   = len != '0 ? LOAD : RESULT;
        rem_d     = len;
        ovf_d     = 1'b0;
        res_sum_d = len != '0 ? res_sum_q : 4'h0;
        res_ovf_d = len != '0 ? res_ovf_q : 1'b0;
      end
      LOAD, ACCUM: if (xfer) begin
        rem_d   = rem_q - CNT_W'(1);
        ovf_d   = ovf_q | (state_q == ACCUM && acc_carry);
        state_d = rem_q == CNT_W'(1) ? WAIT : ACCUM;
      end
      WAIT: begin
        res_sum_d = fin_sum;
        res_ovf_d = ovf_q;
        state_d   = RESULT;
      end
      RESULT: state_d = res_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      ovf_q     <= 1'b0;
      res_sum_q <= 4'h0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      ovf_q     <= ovf_d;
      res_sum_q <= res_sum_d;
      res_ovf_q <= res_ovf_d;
    end
  end
endmodule

// File: tb/tb_accu_seq.sv
// tb_accu_seq: directed test-plan sequences plus random traffic against a transaction-level model.
module tb_accu_seq;
  logic       ck = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, res_ready = 1'b1;
  logic [3:0] len = 4'h0, in_data = 4'h0;
  logic       in_ready, acc_sel, acc_carry, res_ovf, res_valid, busy;
  logic [3:0] acc_a, acc_b, acc_sum, res_sum;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
`ifdef ACCU_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  always #5 ck = ~ck;
  // Downstream accumulator: register loads every edge, no reset.
  logic [3:0] acc_reg = 4'hA;
  logic [4:0] acc_full;
  assign acc_full  = acc_sel ? 5'(acc_b) + 5'(acc_reg) : 5'(acc_b) + 5'(acc_a);
  assign acc_sum   = acc_full[3:0];
  assign acc_carry = acc_full[4];
  always @(posedge ck) acc_reg <= acc_sum;
  accu_seq #(.CNT_W(4)) dut (
    .ck(ck), .rst(rst), .start(start), .len(len), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .acc_a(acc_a), .acc_b(acc_b), .acc_sel(acc_sel), .acc_sum(acc_sum),
    .acc_carry(acc_carry), .res_sum(res_sum), .res_ovf(res_ovf), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );
  // Model: phase 0 idle, 1 collecting operands, 2 summing settles, 3 result offered.
  int m_phase = 0, m_len = 0, m_got = 0, m_total = 0, m_sum = 0, m_ovf = 0;
  always @(posedge ck) begin
    if (rst) begin
      m_phase = 0; m_got = 0; m_total = 0; m_sum = 0; m_ovf = 0;
    end else if (m_phase == 0) begin
      if (start && len == 0) begin
        m_phase = 3; m_sum = 0; m_ovf = 0;
      end else if (start) begin
        m_phase = 1; m_len = int'(len); m_got = 0; m_total = 0;
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_total += int'(in_data);
        m_got++;
        if (m_got == m_len) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 3;
      m_ovf = m_total > 15 ? 1 : 0;
      m_sum = (SAT && m_ovf == 1) ? 15 : m_total % 16;
    end else if (res_ready) m_phase = 0;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge ck) if (chk_en) begin
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("in_ready", int'(in_ready), int'(m_phase == 1));
    chk("res_valid", int'(res_valid), int'(m_phase == 3));
    chk("res_sum", int'(res_sum), m_sum);
    chk("res_ovf", int'(res_ovf), m_ovf);
    chk("acc_a", int'(acc_a), 0);
    chk("acc_sel", int'(acc_sel), int'(!(m_phase == 1 && m_got == 0)));
    chk("acc_b", int'(acc_b), (m_phase == 1 && in_valid) ? int'(in_data) : 0);
  end
  task automatic step();
    @(posedge ck);
    #1;
  endtask
  task automatic at_neg();
    @(negedge ck);
    #2;
  endtask
  task automatic drive(input logic v, input logic [3:0] d);
    step();
    start = 1'b0; in_valid = v; in_data = d;
    at_neg();
  endtask
  task automatic begin_seq(input logic [3:0] l);
    step();
    start = 1'b1; len = l; in_valid = 1'b0;
  endtask
  initial begin
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    at_neg();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_sum", int'(res_sum), 0);
    chk("rst_ready", int'(in_ready), 0);
    begin_seq(4'd3);
    drive(1'b1, 4'd2); chk("t1_sel_load", int'(acc_sel), 0);
    drive(1'b1, 4'd3); chk("t1_sel_acc1", int'(acc_sel), 1);
    drive(1'b1, 4'd4); chk("t1_sel_acc2", int'(acc_sel), 1);
    drive(1'b0, 4'd0); chk("t1_wait_valid", int'(res_valid), 0);
    drive(1'b0, 4'd0);
    chk("t1_valid", int'(res_valid), 1);
    chk("t1_sum", int'(res_sum), 9);
    chk("t1_ovf", int'(res_ovf), 0);
    drive(1'b0, 4'd0); chk("t1_idle", int'(busy), 0);
    begin_seq(4'd2);
    drive(1'b1, 4'd9);
    drive(1'b1, 4'd8);
    drive(1'b0, 4'd0);
    drive(1'b0, 4'd0);
    chk("t2_sum", int'(res_sum), SAT ? 15 : 1);
    chk("t2_ovf", int'(res_ovf), 1);
    drive(1'b0, 4'd0);
    begin_seq(4'd3);
    drive(1'b1, 4'd1);
    drive(1'b0, 4'd5); chk("t3_gap_b", int'(acc_b), 0); chk("t3_gap_sel", int'(acc_sel), 1);
    drive(1'b0, 4'd5); chk("t3_gap_b2", int'(acc_b), 0);
    drive(1'b1, 4'd5);
    drive(1'b1, 4'd7);
    drive(1'b0, 4'd0);
    drive(1'b0, 4'd0);
    chk("t3_sum", int'(res_sum), 13);
    chk("t3_ovf", int'(res_ovf), 0);
    drive(1'b0, 4'd0);
    res_ready = 1'b0;
    begin_seq(4'd2);
    drive(1'b1, 4'd1);
    drive(1'b1, 4'd2);
    drive(1'b0, 4'd0);
    drive(1'b0, 4'd0); chk("t4_valid", int'(res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      start = i == 2; len = 4'd5;
      at_neg();
      chk("t4_hold_valid", int'(res_valid), 1);
      chk("t4_hold_busy", int'(busy), 1);
      chk("t4_hold_sum", int'(res_sum), 3);
    end
    step();
    start = 1'b0; res_ready = 1'b1;
    at_neg(); chk("t4_still_valid", int'(res_valid), 1);
    drive(1'b0, 4'd0);
    chk("t4_idle", int'(busy), 0);
    chk("t4_no_load", int'(in_ready), 0);
    begin_seq(4'd4);
    drive(1'b1, 4'd1);
    drive(1'b1, 4'd2);
    step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    at_neg();
    chk("t5_busy", int'(busy), 0);
    chk("t5_ready", int'(in_ready), 0);
    chk("t5_valid", int'(res_valid), 0);
    begin_seq(4'd1);
    drive(1'b0, 4'd0);
    drive(1'b1, 4'd6);
    drive(1'b0, 4'd0);
    drive(1'b0, 4'd0);
    chk("t5_sum", int'(res_sum), 6);
    chk("t5_ovf", int'(res_ovf), 0);
    drive(1'b0, 4'd0);
    begin_seq(4'd0);
    drive(1'b0, 4'd0);
    chk("t6_valid", int'(res_valid), 1);
    chk("t6_sum", int'(res_sum), 0);
    chk("t6_ovf", int'(res_ovf), 0);
    chk("t6_ready", int'(in_ready), 0);
    drive(1'b0, 4'd0);
    for (int i = 0; i < 4000; i++) begin
      step();
      rst       = $urandom_range(0, 149) == 0;
      start     = $urandom_range(0, 3) == 0;
      len       = 4'($urandom);
      in_valid  = $urandom_range(0, 2) != 0;
      in_data   = 4'($urandom);
      res_ready = $urandom_range(0, 1) == 1;
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
